r2r_sar_adc: RTL and testbench
==============================

Name: r2r_sar_adc

Overview:
Successive-approximation ADC controller, the receive-side counterpart of the sine LUT → R2R DAC path. It drives the same 8-bit PMOD R2R ladder with trial codes and reads an external analog comparator (Vin vs. ladder output) through a PMOD input pin. After a binary search it presents an 8-bit sample with a one-cycle valid strobe. Typical uses are measuring the synth's analog output on-board and reading a control voltage such as a pot.

Parameters:
SETTLE_CYCLES, 100, clk cycles the ladder and comparator are given to settle per trial bit. Legal range 3..65535. The minimum of 3 covers the 2-flop synchronizer lag.
WIDTH, 8, resolution in bits. Fixed at 8 for the PMOD ladder; parameterized only for bench reuse.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
en  in  1  block enable; low aborts any conversion
start  in  1  single-cycle request to begin a conversion
auto_run  in  1  when high, a new conversion starts immediately after each DONE
comp_in  in  1  asynchronous comparator output; 1 means Vin >= ladder voltage
dac_code  out  WIDTH  trial/final code to the R2R ladder PMOD pins
busy  out  1  high while a conversion is in progress
sample  out  WIDTH  last completed conversion result
sample_valid  out  1  one-cycle pulse when sample updates

Behaviour:
- Reset (rst=1 at a clk edge, dominant over everything): state=IDLE, dac_code=0x00, sample=0x00, sample_valid=0, busy=0, bit index=WIDTH-1, settle timer=0, synchronizer flops=0.
- comp_in passes through a 2-flop synchronizer giving comp_s. Only comp_s is used.
- States: IDLE, SETTLE, DECIDE, DONE.
- IDLE: busy=0. On en & (start | auto_run):
  - dac_code <= 1<<(WIDTH-1), i.e. 0x80
  - bit_idx <= WIDTH-1, timer <= 0
  - state goes to SETTLE.
- SETTLE: busy=1. Timer increments each cycle. When timer==SETTLE_CYCLES-1, go to DECIDE. SETTLE lasts exactly SETTLE_CYCLES cycles.
- DECIDE: one cycle, busy=1.
  - If comp_s=0, clear dac_code[bit_idx].
  - If bit_idx==0, go to DONE.
  - Otherwise set dac_code[bit_idx-1], decrement bit_idx, timer <= 0, and return to SETTLE.
  - Both the clear and the set land in the same cycle.
- DONE: one cycle.
  - sample <= dac_code (already final).
  - sample_valid=1 (registered, high only in this cycle); busy=1.
  - If en & auto_run, restart exactly as the IDLE accept (same cycle, no IDLE gap). Otherwise go to IDLE.
- Latency: if start is sampled at edge k, sample_valid is high in cycle k+1+WIDTH*(SETTLE_CYCLES+1). With defaults that is k+809.
- dac_code holds the final result in IDLE until the next conversion starts.
- start while busy: ignored, not queued.
- start and auto_run both high in IDLE: a single conversion starts.
- en deasserted in any non-IDLE state: next state IDLE, busy=0, no sample_valid, sample unchanged, dac_code holds its current partial value.
- rst mid-conversion: full reset values on the next cycle, with no sample_valid.
- Arithmetic: all codes unsigned WIDTH bits. The timer is 16 bits with no wrap in legal use.

Decomposition:
- Shared package adc_pkg:
  - state enum (IDLE, SETTLE, DECIDE, DONE)
  - DAC_WIDTH=8
  - DAC_MIDSCALE=8'h80
  - default SETTLE_CYCLES
- DAC_WIDTH and DAC_MIDSCALE are reused by lutSin-style generators.
- One sub-module, sync_2ff: a generic 1-bit two-flop synchronizer with sync active-high reset, reusable for the other PMOD inputs.

Test Plan:
Bench setup: SETTLE_CYCLES=4 and a comparator model comp_in = (vin >= dac_code), evaluated combinationally.
1. Reset, then vin=0xA5 and a start pulse at edge k.
   - busy high from k+1.
   - dac_code trial sequence 0x80, C0, A0, B0, A8, A4, A6, A5.
   - sample=0xA5 with sample_valid pulsing exactly at k+41, then busy=0.
2. Endpoints.
   - vin=0x00 gives sample 0x00.
   - vin=0xFF gives 0xFF.
   - vin=0x80 gives 0x80.
   - sample_valid is a single cycle each time.
3. start re-pulsed at k+10 and k+20 during a conversion: ignored, still exactly one sample_valid at k+41.
4. auto_run=1, vin stepping 0x10 → 0x3C between conversions.
   - Back-to-back results 0x10 then 0x3C.
   - sample_valid pulses 41 cycles apart, with no IDLE cycle in between.
5. en dropped at k+15: busy=0 at k+16, no sample_valid, sample retains its prior value.
   - Re-enable and start: a normal conversion completes.
6. rst asserted at k+20, deasserted at k+22: all outputs at reset values (dac_code=0, sample=0, busy=0).
   - A subsequent conversion with vin=0x5A yields 0x5A.

Source files
------------

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the R2R ladder ADC/DAC path
package adc_pkg;

    localparam int               DAC_WIDTH             = 8;
    localparam logic [7:0]       DAC_MIDSCALE          = 8'h80;
    localparam int               DEFAULT_SETTLE_CYCLES = 100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } adc_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 1-bit two-flop synchronizer for asynchronous PMOD inputs
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give metastability a full cycle to resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/r2r_sar_adc.sv
// rtl/r2r_sar_adc.sv - successive-approximation ADC controller driving an R2R ladder
module r2r_sar_adc
    import adc_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int WIDTH         = DAC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             auto_run,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid
);

    localparam int               IDXW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP    = IDXW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIDSCALE   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [15:0]      TIMER_LAST = 16'(SETTLE_CYCLES - 1);

    adc_state_t       state;
    logic [IDXW-1:0]  bit_idx;
    logic [15:0]      timer;
    logic             comp_s;
    logic [WIDTH-1:0] decide_code;

    sync_2ff u_comp_sync (
        .clk (clk),
        .rst (rst),
        .d   (comp_in),
        .q   (comp_s)
    );

    // Code after a decision: drop the trial bit if Vin is below the ladder, then arm the next bit
    always_comb begin
        decide_code = dac_code;
        if (!comp_s) begin
            decide_code[bit_idx] = 1'b0;
        end
        if (bit_idx != '0) begin
            decide_code[bit_idx - 1'b1] = 1'b1;
        end
    end

    // Conversion sequencer: settle each trial bit, decide it, publish the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            dac_code     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            bit_idx      <= IDX_TOP;
            timer        <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (en && (start || auto_run)) begin
                        dac_code <= MIDSCALE;
                        bit_idx  <= IDX_TOP;
                        timer    <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!en) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                        if (timer == TIMER_LAST) begin
                            state <= ST_DECIDE;
                        end
                    end
                end
                ST_DECIDE: begin
                    if (!en) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (bit_idx == '0) begin
                        dac_code     <= decide_code;
                        sample       <= decide_code;
                        sample_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        dac_code <= decide_code;
                        bit_idx  <= bit_idx - 1'b1;
                        timer    <= '0;
                        state    <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    if (en && auto_run) begin
                        dac_code <= MIDSCALE;
                        bit_idx  <= IDX_TOP;
                        timer    <= '0;
                        state    <= ST_SETTLE;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r2r_sar_adc.sv
// tb/tb_r2r_sar_adc.sv - self-checking bench for r2r_sar_adc with an ideal comparator model
module tb_r2r_sar_adc;

    localparam int S    = 4;
    localparam int W    = 8;
    localparam int CONV = W * (S + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         start = 1'b0;
    logic         auto_run = 1'b0;
    logic         comp_in;
    logic [W-1:0] dac_code;
    logic         busy;
    logic [W-1:0] sample;
    logic         sample_valid;
    logic [W-1:0] vin = '0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign comp_in = (vin >= dac_code);

    r2r_sar_adc #(.SETTLE_CYCLES(S), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start),
        .auto_run     (auto_run),
        .comp_in      (comp_in),
        .dac_code     (dac_code),
        .busy         (busy),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    // Ideal binary search: trial j is the running result plus the j-th halving weight
    function automatic logic [7:0] trial_at(input logic [7:0] v, input int j);
        int code = 0;
        int trial = 0;
        for (int k = 0; k < 8; k++) begin
            trial = code + (128 >> k);
            if (k == j) return trial[7:0];
            if (int'(v) >= trial) code = trial;
        end
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_conv(input logic [7:0] v, input bit repulse, input string tag);
        int nvalid = 0;
        vin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_k1"}, busy, 1'b1);
        chk({tag, "_trial0"}, dac_code, trial_at(v, 0));
        for (int i = 1; i <= CONV; i++) begin
            start = repulse && (i == 10 || i == 20);
            tick();
            start = 1'b0;
            if (sample_valid) nvalid++;
            if ((i % (S + 1)) == 0 && i < CONV)
                chk({tag, "_trial"}, dac_code, trial_at(v, i / (S + 1)));
        end
        chk({tag, "_valid_at_k41"}, sample_valid, 1'b1);
        chk({tag, "_valid_count"}, nvalid, 1);
        chk({tag, "_sample"}, sample, v);
        tick();
        chk({tag, "_valid_drop"}, sample_valid, 1'b0);
        chk({tag, "_busy_drop"}, busy, 1'b0);
        chk({tag, "_dac_hold"}, dac_code, v);
    endtask

    initial begin
        int nvalid;
        int lowcnt;
        logic [7:0] prev;

        repeat (3) tick();
        chk("reset_dac", dac_code, 8'h00);
        chk("reset_sample", sample, 8'h00);
        chk("reset_valid", sample_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 1'b0);

        run_conv(8'hA5, 1'b0, "t1");

        run_conv(8'h00, 1'b0, "t2_zero");
        run_conv(8'hFF, 1'b0, "t2_full");
        run_conv(8'h80, 1'b0, "t2_mid");

        run_conv(8'h6B, 1'b1, "t3_restart");

        vin      = 8'h10;
        auto_run = 1'b1;
        tick();
        chk("t4_busy_k1", busy, 1'b1);
        lowcnt = 0;
        nvalid = 0;
        for (int i = 1; i <= CONV; i++) begin
            tick();
            if (!busy) lowcnt++;
            if (sample_valid) nvalid++;
        end
        chk("t4_first_valid", sample_valid, 1'b1);
        chk("t4_first_sample", sample, 8'h10);
        vin    = 8'h3C;
        nvalid = 0;
        for (int i = 1; i <= CONV + 1; i++) begin
            tick();
            if (!busy) lowcnt++;
            if (sample_valid) nvalid++;
        end
        auto_run = 1'b0;
        chk("t4_second_valid_41", sample_valid, 1'b1);
        chk("t4_second_count", nvalid, 1);
        chk("t4_second_sample", sample, 8'h3C);
        chk("t4_no_idle_gap", lowcnt, 0);
        tick();
        chk("t4_stop_busy", busy, 1'b0);

        prev  = sample;
        vin   = 8'h37;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) en = 1'b0;
            tick();
        end
        chk("t5_busy_k16", busy, 1'b0);
        chk("t5_no_valid", sample_valid, 1'b0);
        chk("t5_dac_partial", dac_code, trial_at(8'h37, 2));
        nvalid = 0;
        for (int i = 0; i < CONV + 5; i++) begin
            tick();
            if (sample_valid) nvalid++;
        end
        chk("t5_no_valid_after", nvalid, 0);
        chk("t5_sample_kept", sample, prev);
        en = 1'b1;
        run_conv(8'h37, 1'b0, "t5_reen");

        vin    = 8'h99;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        nvalid = 0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (sample_valid) nvalid++;
        end
        rst = 1'b1;
        tick();
        chk("t6_rst_dac", dac_code, 8'h00);
        chk("t6_rst_sample", sample, 8'h00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_valid", sample_valid, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_idle_busy", busy, 1'b0);
        chk("t6_no_valid", nvalid, 0);
        run_conv(8'h5A, 1'b0, "t6_after");

        for (int r = 0; r < 6; r++) begin
            run_conv(8'($urandom_range(0, 255)), 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
